// File: rtl/unidad_control_pkg.sv
// rtl/unidad_control_pkg.sv - shared state encoding for the shift-and-add multiplier controller
package unidad_control_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_LOAD) || (s == S_TEST) || (s == S_ADD) || (s == S_SHIFT);
  endfunction

endpackage

// File: rtl/contador_iter.sv
// rtl/contador_iter.sv - iteration down-counter with load, clear and last-iteration flag
module contador_iter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  logic [CW-1:0] r_count;

  // Clear beats load beats decrement; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == CW'(1));

endmodule

// File: rtl/unidad_control_mult.sv
// rtl/unidad_control_mult.sv - Moore controller sequencing load/add/shift for an N-bit multiplier
module unidad_control_mult
  import unidad_control_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          xs,
  input  logic          abort,
  input  logic          q0,
  output logic          load,
  output logic          add,
  output logic          shift,
  output logic          busy,
  output logic          fin,
  output logic [CW-1:0] iter
);

  state_t        r_state;
  state_t        w_state_next;
  logic          w_cnt_clr;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic          w_last;
  logic [CW-1:0] w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      S_IDLE:  if (xs) w_state_next = S_LOAD;
      S_LOAD: begin
        w_cnt_load   = 1'b1;
        w_state_next = S_TEST;
      end
      S_TEST:  w_state_next = q0 ? S_ADD : S_SHIFT;
      S_ADD:   w_state_next = S_SHIFT;
      S_SHIFT: begin
        w_cnt_dec    = 1'b1;
        w_state_next = w_last ? S_DONE : S_TEST;
      end
      // Holding here while xs stays high is what stops a held request from re-triggering.
      S_DONE:  if (!xs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (is_busy(r_state) && abort) begin
      w_state_next = S_IDLE;
      w_cnt_clr    = 1'b1;
      w_cnt_load   = 1'b0;
      w_cnt_dec    = 1'b0;
    end
  end

  contador_iter #(
    .CW(CW)
  ) u_contador (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_load  (w_cnt_load),
    .i_dec   (w_cnt_dec),
    .i_val   (CW'(N)),
    .o_count (w_count),
    .o_last  (w_last)
  );

  assign load  = (r_state == S_LOAD);
  assign add   = (r_state == S_ADD);
  assign shift = (r_state == S_SHIFT);
  assign busy  = is_busy(r_state);
  assign fin   = (r_state == S_DONE);
  assign iter  = w_count;

endmodule

// File: tb/tb_unidad_control_mult.sv
// tb/tb_unidad_control_mult.sv - scoreboard bench for the multiplier controller at N=4 and N=32
module tb_unidad_control_mult;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_xs = 1'b0, a_abort = 1'b0, a_q0;
  logic       a_load, a_add, a_shift, a_busy, a_fin;
  logic [2:0] a_iter;
  logic       b_xs = 1'b0, b_abort = 1'b0, b_q0;
  logic       b_load, b_add, b_shift, b_busy, b_fin;
  logic [5:0] b_iter;

  unidad_control_mult #(.N(4)) u_a (
    .clk(clk), .reset(reset), .xs(a_xs), .abort(a_abort), .q0(a_q0),
    .load(a_load), .add(a_add), .shift(a_shift), .busy(a_busy), .fin(a_fin), .iter(a_iter)
  );

  unidad_control_mult #(.N(32)) u_b (
    .clk(clk), .reset(reset), .xs(b_xs), .abort(b_abort), .q0(b_q0),
    .load(b_load), .add(b_add), .shift(b_shift), .busy(b_busy), .fin(b_fin), .iter(b_iter)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural datapaths driven by the controller strobes.
  logic [3:0]  a_m_in = '0, a_q_in = '0, a_acc = '0, a_q = '0;
  logic        a_c = 1'b0;
  logic [31:0] b_m_in = '0, b_q_in = '0, b_acc = '0, b_q = '0;
  logic        b_c = 1'b0;

  always @(posedge clk) begin
    if (a_load) begin
      a_acc <= '0; a_c <= 1'b0; a_q <= a_q_in;
    end else if (a_add) begin
      {a_c, a_acc} <= {1'b0, a_acc} + {1'b0, a_m_in};
    end else if (a_shift) begin
      a_acc <= {a_c, a_acc[3:1]}; a_q <= {a_acc[0], a_q[3:1]}; a_c <= 1'b0;
    end
    if (b_load) begin
      b_acc <= '0; b_c <= 1'b0; b_q <= b_q_in;
    end else if (b_add) begin
      {b_c, b_acc} <= {1'b0, b_acc} + {1'b0, b_m_in};
    end else if (b_shift) begin
      b_acc <= {b_c, b_acc[31:1]}; b_q <= {b_acc[0], b_q[31:1]}; b_c <= 1'b0;
    end
  end

  assign a_q0 = a_q[0];
  assign b_q0 = b_q[0];

  typedef struct {
    int          lat;
    int          adds;
    int          shifts;
    logic [63:0] prod;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int a_t = 0, a_adds = 0, a_shifts = 0;
  logic a_fin_q = 1'b0;
  int b_t = 0, b_adds = 0, b_shifts = 0;
  logic b_fin_q = 1'b0;

  always @(negedge clk) begin
    if (a_load) begin
      a_t = 0; a_adds = 0; a_shifts = 0;
    end else begin
      a_t++;
    end
    if (a_add)   a_adds++;
    if (a_shift) a_shifts++;
    if (a_fin && !a_fin_q) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_fin", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_latency", a_t, e.lat);
        chk("a_adds", a_adds, e.adds);
        chk("a_shifts", a_shifts, e.shifts);
        chk("a_product", {56'd0, a_acc, a_q}, e.prod);
      end
    end
    a_fin_q = a_fin;
  end

  always @(negedge clk) begin
    if (b_load) begin
      b_t = 0; b_adds = 0; b_shifts = 0;
    end else begin
      b_t++;
    end
    if (b_add)   b_adds++;
    if (b_shift) b_shifts++;
    if (b_fin && !b_fin_q) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_fin", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_latency", b_t, e.lat);
        chk("b_adds", b_adds, e.adds);
        chk("b_shifts", b_shifts, e.shifts);
        chk("b_product", {b_acc, b_q}, e.prod);
      end
    end
    b_fin_q = b_fin;
  end

  function automatic logic sig(input int w);
    case (w)
      0: return a_load;
      1: return a_fin;
      2: return a_shift;
      3: return b_fin;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input int bound, input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      got = sig(w);
    end
    chk(name, got, 1);
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 a_xs = 1'b1;
    @(posedge clk); #1 a_xs = 1'b0;
  endtask

  task automatic push_a(input int lat, input int adds, input int shifts, input logic [63:0] prod);
    exp_t e;
    e.lat = lat; e.adds = adds; e.shifts = shifts; e.prod = prod;
    qa.push_back(e);
  endtask

  initial begin
    int idx, fc, lc, adds_seen, fin_seen, maxi;
    exp_t eb;

    #1;
    chk("reset_a_outs", {a_load, a_add, a_shift, a_busy, a_fin, a_iter}, 0);
    chk("reset_b_outs", {b_load, b_add, b_shift, b_busy, b_fin, b_iter}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 13 * 1011b = 143, three adds
    a_m_in = 4'd13; a_q_in = 4'b1011;
    push_a(12, 3, 4, 64'd143);
    pulse_a();
    @(negedge clk);
    chk("t1_load", a_load, 1);
    wait_for(1, 30, "t1_fin_seen");
    @(negedge clk);
    chk("t1_fin_width", {a_fin, a_busy}, 0);

    // zero multiplier: no adds, iter counts down across the shifts
    a_m_in = 4'd5; a_q_in = 4'b0000;
    push_a(9, 0, 4, 64'd0);
    pulse_a();
    idx = 0;
    for (int i = 0; i < 20 && !a_fin; i++) begin
      @(negedge clk);
      if (a_shift) begin
        chk("t2_iter_at_shift", a_iter, 4 - idx);
        idx++;
      end
    end
    chk("t2_fin", a_fin, 1);
    chk("t2_shift_count", idx, 4);
    chk("t2_iter_done", a_iter, 0);
    @(negedge clk);

    // xs held through completion: fin holds, no second load
    a_m_in = 4'd7; a_q_in = 4'b0110;
    push_a(11, 2, 4, 64'd42);
    @(posedge clk); #1 a_xs = 1'b1;
    wait_for(1, 30, "t3_fin_seen");
    fc = 0; lc = 0;
    repeat (5) begin
      @(negedge clk);
      fc += int'(a_fin); lc += int'(a_load);
    end
    chk("t3_hold_fin", fc, 5);
    chk("t3_hold_noload", lc, 0);
    @(posedge clk); #1 a_xs = 1'b0;
    @(negedge clk);
    chk("t3_fin_before_edge", a_fin, 1);
    @(negedge clk);
    chk("t3_dropped_idle", {a_fin, a_busy}, 0);
    push_a(11, 2, 4, 64'd42);
    @(posedge clk); #1 a_xs = 1'b1;
    @(negedge clk);
    chk("t3_idle_before_edge", a_load, 0);
    @(negedge clk);
    chk("t3_reraise_load", a_load, 1);
    a_xs = 1'b0;
    wait_for(1, 30, "t3_second_fin");
    @(negedge clk);

    // abort during the second add
    a_m_in = 4'd13; a_q_in = 4'b1011;
    pulse_a();
    adds_seen = 0;
    for (int i = 0; i < 30 && adds_seen < 2; i++) begin
      @(negedge clk);
      if (a_add) adds_seen++;
    end
    chk("t4_second_add", adds_seen, 2);
    a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_idle", {a_busy, a_load, a_add, a_shift}, 0);
    chk("t4_abort_iter", a_iter, 0);
    fin_seen = 0;
    repeat (20) begin
      @(negedge clk);
      fin_seen += int'(a_fin);
    end
    chk("t4_no_fin", fin_seen, 0);

    // asynchronous reset between edges while shifting
    pulse_a();
    wait_for(2, 30, "t5_shift_seen");
    #2 reset = 1'b1;
    #1;
    chk("t5_reset_outs", {a_load, a_add, a_shift, a_busy, a_fin, a_iter}, 0);
    @(negedge clk);
    reset = 1'b0;
    a_m_in = 4'd9; a_q_in = 4'b0101;
    push_a(11, 2, 4, 64'd45);
    pulse_a();
    wait_for(1, 30, "t5_clean_fin");
    @(negedge clk);

    // N=32, all-ones multiplier: 3 * (2^32-1)
    b_m_in = 32'd3; b_q_in = 32'hFFFF_FFFF;
    eb.lat = 97; eb.adds = 32; eb.shifts = 32; eb.prod = 64'h0000_0002_FFFF_FFFD;
    qb.push_back(eb);
    @(posedge clk); #1 b_xs = 1'b1;
    @(posedge clk); #1 b_xs = 1'b0;
    maxi = 0;
    for (int i = 0; i < 150 && !b_fin; i++) begin
      @(negedge clk);
      if (int'(b_iter) > maxi) maxi = int'(b_iter);
    end
    chk("t6_fin", b_fin, 1);
    chk("t6_iter_max", maxi, 32);
    chk("t6_iter_done", b_iter, 0);

    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unidad_control_mult.md
# unidad_control_mult

Parametrised controller for an N-bit shift-and-add multiplier datapath. It sequences load, conditional add and shift micro-operations from a start/finish handshake. It generalises the fixed single-input control unit with:
- a width parameter and internal iteration counter
- a datapath status input (multiplier LSB)
- an abort input
- a level handshake that holds `fin` until `xs` is released

It sits beside the multiplier datapath and drives only its control lines.

## Interface
- `N`, 8, operand width in bits (iterations per product); legal range 2..32
- `CW`, `$clog2(N+1)`, iteration-counter width (derived localparam, not overridable)

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `xs`  in  1  start request, level; sampled only in S_IDLE and S_DONE
- `abort`  in  1  synchronous abort, active-high
- `q0`  in  1  current multiplier LSB from datapath
- `load`  out  1  load operands, clear accumulator
- `add`  out  1  accumulator <= accumulator + multiplicand
- `shift`  out  1  shift {accumulator, multiplier} right one bit
- `busy`  out  1  high in S_LOAD, S_TEST, S_ADD, S_SHIFT
- `fin`  out  1  product valid; high only in S_DONE
- `iter`  out  CW  remaining iterations (counter value)

## Operation
- Moore FSM with six states: S_IDLE, S_LOAD, S_TEST, S_ADD, S_SHIFT, S_DONE. All outputs decode from current state and counter only; every output defaults to 0.
- S_IDLE: `xs`=1 -> S_LOAD; else stay.
- S_LOAD: `load`=1; counter <= N; -> S_TEST.
- S_TEST: no strobe.
  - `q0`=1 -> S_ADD
  - `q0`=0 -> S_SHIFT
- S_ADD: `add`=1; -> S_SHIFT.
- S_SHIFT: `shift`=1; counter <= counter-1.
  - counter==1 (before decrement) -> S_DONE
  - else -> S_TEST
- S_DONE: `fin`=1. Next state is decided by `xs` at the clock edge:
  - `xs`=1 -> stay (handshake hold)
  - `xs`=0 -> S_IDLE
  - A new product therefore needs `xs` to go low, then high again.
- Abort: `abort`=1 in any busy state -> S_IDLE next edge. Counter <= 0, no `fin`, and the strobe of the current cycle is still issued. In S_IDLE and S_DONE, `abort` is ignored.
- Priority in busy states: abort > normal transition.
- Counter arithmetic:
  - unsigned, CW bits
  - decrements only in S_SHIFT
  - never wraps: S_SHIFT always leaves with counter ≥ 0, because exit happens at counter==1
- Only one of `load`/`add`/`shift` is ever high in a cycle.
- Undefined state encodings -> S_IDLE.

## Timing
- Reset, asynchronous:
  - state S_IDLE, counter 0
  - `load`, `add`, `shift`, `busy`, `fin` = 0; `iter` = 0
  - takes effect immediately, including mid-operation; no `fin` is produced for the interrupted product.
- Start latency: `load` high in the cycle after the edge that samples `xs`=1.
- Busy duration: 1 + N + N + k cycles, where k = number of ones in the multiplier. `fin` rises on the edge after the last `shift`.
- `q0` must be stable by the S_TEST edge and reflect the already-shifted datapath value.
- Minimum `fin` width is 1 cycle, when `xs` is already low on entry to S_DONE.
- `xs` held high continuously yields exactly one product.

## Structure
- Shared package `unidad_control_pkg`:
  - state localparams (3-bit encoding S_IDLE=0 … S_DONE=5)
  - state width constant
- One natural sub-module, `contador_iter`: CW-bit down-counter with synchronous load/decrement and asynchronous reset, exposing a `last` flag (count==1).
- The FSM holds a state register plus a next-state/output always block.

## Test plan
- N=4, multiplier 1011, `xs` pulse:
  - `load` 1 cycle, then 3 `add` strobes and 4 `shift` strobes
  - `fin` high exactly 12 cycles after `load`
  - behavioural datapath product = multiplicand·11
- N=4, multiplier 0000: no `add`; `fin` 9 cycles after `load`; `iter` reads 4,3,2,1,0 across the shifts.
- `xs` held high through completion:
  - `fin` stays high; no second `load`
  - dropping `xs` -> S_IDLE next edge
  - re-raising `xs` -> new `load`
- `abort` asserted during the second S_ADD:
  - next cycle S_IDLE, `busy`=0, `iter`=0
  - `fin` never rises
- `reset` pulsed mid-shift (asynchronous, between edges): all outputs 0 immediately; the next `xs` starts a clean product.
- N=32, multiplier all ones: 32 `add` strobes, `fin` after 97 cycles; counter never wraps.
